booth_multiplier_r4: RTL and testbench

BOOTH_MULTIPLIER_R4 -- requirements
Module: booth_multiplier_r4

---
 rtl/booth_multiplier_r4.sv | 107 ++++++++++
 tb/tb_booth_multiplier_r4.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/booth_multiplier_r4.sv
// Sequential radix-4 Booth multiplier.
// Retires one Booth digit per cycle from a (WIDTH+2)-bit extended multiplier,
// so the signed and unsigned modes share one datapath and have the same latency.
module booth_multiplier_r4 #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand_a,
    input  logic [WIDTH-1:0]   multiplier_b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    // WIDTH+2 extended multiplier -> WIDTH/2+1 digits, the last one covering
    // the extension bits so unsigned operands need no special case.
    localparam int DIGITS = WIDTH/2 + 1;
    localparam int EXT_W  = WIDTH + 2;
    // Headroom above 2*WIDTH+4 keeps the pre-shift partial sum from overflowing.
    localparam int ACC_W  = 2*WIDTH + 6;
    localparam int CNT_W  = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                   state_q;
    logic signed [EXT_W-1:0]  a_q;
    logic        [EXT_W:0]    b_q;      // extended multiplier with b[-1]=0 appended
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic        [EXT_W:0]    b_d;
    logic        [CNT_W-1:0]  cnt_q;
    logic [2*WIDTH-1:0]       product_q;

    logic        [EXT_W-1:0]  a_ext, b_ext;
    logic signed [ACC_W-1:0]  a_wide, pp, sum;

    assign a_ext = is_signed ? {{2{multiplicand_a[WIDTH-1]}}, multiplicand_a}
                             : {2'b00, multiplicand_a};
    assign b_ext = is_signed ? {{2{multiplier_b[WIDTH-1]}}, multiplier_b}
                             : {2'b00, multiplier_b};

    // Multiplicand aligned at bit EXT_W: after DIGITS shifts of 2 it lands at bit 0.
    assign a_wide = {{(ACC_W-2*EXT_W){a_q[EXT_W-1]}}, a_q, {EXT_W{1'b0}}};

    // Booth digit select, accumulate, then arithmetic shift right by 2.
    always_comb begin
        pp = '0;
        unique case (b_q[2:0])
            3'b001, 3'b010: pp = a_wide;
            3'b011:         pp = a_wide <<< 1;
            3'b100:         pp = -(a_wide <<< 1);
            3'b101, 3'b110: pp = -a_wide;
            default:        pp = '0;
        endcase
        sum   = acc_q + pp;
        acc_d = sum >>> 2;
        b_d   = b_q >> 2;
    end

    // Control FSM and datapath registers; the final cycle of CALC registers the result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q     <= a_ext;
                        b_q     <= {b_ext, 1'b0};
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    if (cnt_q == CNT_W'(DIGITS)) begin
                        product_q <= acc_q[2*WIDTH-1:0];
                        state_q   <= DONE;
                    end else begin
                        acc_q <= acc_d;
                        b_q   <= b_d;
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == CALC);
    assign out_valid = (state_q == DONE);
    assign product   = product_q;

endmodule

// File: tb/tb_booth_multiplier_r4.sv
// Directed bench for booth_multiplier_r4 at WIDTH=16.
module tb_booth_multiplier_r4;

    localparam int W = 16;

    logic           clk, reset;
    logic           in_valid, in_ready;
    logic [W-1:0]   multiplicand_a, multiplier_b;
    logic           is_signed;
    logic           out_valid, out_ready;
    logic [2*W-1:0] product;
    logic           busy;

    int checks = 0;
    int errors = 0;
    int lat;
    logic [2*W-1:0] held;

    booth_multiplier_r4 #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .multiplicand_a(multiplicand_a), .multiplier_b(multiplier_b),
        .is_signed(is_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Present operands for exactly one edge (design is in IDLE).
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        in_valid = 1'b1; multiplicand_a = a; multiplier_b = b; is_signed = s;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid, bounded.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!out_valid && n < 40);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic [2*W-1:0] exp);
        int n;
        start_op(a, b, s);
        check({tag, " busy"}, busy, 1'b1);
        wait_done(n);
        check({tag, " latency"}, n, 10);
        check({tag, " product"}, product, exp);
        release_out();
        check({tag, " in_ready"}, in_ready, 1'b1);
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        multiplicand_a = '0; multiplier_b = '0; is_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", in_ready, 1'b1);
        check("rst out_valid", out_valid, 1'b0);
        check("rst busy", busy, 1'b0);
        check("rst product", product, 32'h0);
        reset = 1'b1;

        // Accepted on the first edge after release.
        op("s -3*5", 16'hFFFD, 16'h0005, 1'b1, 32'hFFFF_FFF1);
        op("u ffff^2", 16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001);
        op("s -1*-1", 16'hFFFF, 16'hFFFF, 1'b1, 32'h0000_0001);
        op("s min*min", 16'h8000, 16'h8000, 1'b1, 32'h4000_0000);
        op("s min*max", 16'h8000, 16'h7FFF, 1'b1, 32'hC000_8000);
        op("u 1234*5678", 16'h1234, 16'h5678, 1'b0, 32'h0626_0060);

        // Output backpressure: result held for 5 cycles.
        start_op(16'd3, 16'd4, 1'b0);
        wait_done(lat);
        check("bp latency", lat, 10);
        check("bp product", product, 32'd12);
        held = product;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp out_valid", out_valid, 1'b1);
            check("bp stable", product, held);
            check("bp in_ready", in_ready, 1'b0);
        end
        release_out();
        check("bp idle in_ready", in_ready, 1'b1);
        check("bp idle out_valid", out_valid, 1'b0);
        check("bp idle product", product, 32'd12);

        // Reset during CALC cycle 4.
        start_op(16'd100, 16'd100, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        check("pre-abort busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("abort in_ready", in_ready, 1'b1);
        check("abort out_valid", out_valid, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort product", product, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        op("post-abort 7*6", 16'd7, 16'd6, 1'b0, 32'h0000_002A);

        // in_valid kept high with changing operands while busy.
        start_op(16'd9, 16'hFFF5, 1'b1);   // 9 * -11 = -99
        in_valid = 1'b1;
        lat = 0;
        do begin
            multiplicand_a = W'($urandom);
            multiplier_b   = W'($urandom);
            is_signed      = 1'($urandom);
            @(posedge clk); #1;
            lat++;
        end while (!out_valid && lat < 40);
        in_valid = 1'b0;
        check("iv-hold latency", lat, 10);
        check("iv-hold product", product, 32'hFFFF_FF9D);
        release_out();
        check("iv-hold in_ready", in_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
